// File: rtl/alu_gates_if.sv
// Operand/result bundle for the bitwise logic unit: operands and op come in,
// combinational gate outputs and the registered result go out.
interface alu_gates_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [1:0]       op;
    logic             in_valid;
    logic [WIDTH-1:0] and_out;
    logic [WIDTH-1:0] or_out;
    logic [WIDTH-1:0] nor_out;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             out_valid;

    modport master (
        output a, b, op, in_valid,
        input  and_out, or_out, nor_out, result, zero, out_valid
    );

    modport slave (
        input  a, b, op, in_valid,
        output and_out, or_out, nor_out, result, zero, out_valid
    );
endinterface

// File: rtl/alu_gates.sv
// Bitwise logic unit: zero-latency AND/OR/NOR for the result mux, plus a
// one-cycle registered op-selected result with zero flag for writeback.
module alu_gates #(
    parameter int WIDTH = 32
) (
    input  logic        clk,
    input  logic        reset,
    alu_gates_if.slave  bus
);
    localparam logic [1:0] OP_AND = 2'b00;
    localparam logic [1:0] OP_OR  = 2'b01;
    localparam logic [1:0] OP_NOR = 2'b10;

    logic [WIDTH-1:0] w_sel;
    logic             w_zero_next;
    logic [WIDTH-1:0] r_result;
    logic             r_zero;
    logic             r_out_valid;

    // The reserved op yields all zeros, so it also raises the zero flag.
    function automatic logic [WIDTH-1:0] f_select(
        input logic [1:0]       op,
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b
    );
        logic [WIDTH-1:0] v;
        case (op)
            OP_AND:  v = a & b;
            OP_OR:   v = a | b;
            OP_NOR:  v = ~(a | b);
            default: v = {WIDTH{1'b0}};
        endcase
        return v;
    endfunction

    assign bus.and_out = bus.a & bus.b;
    assign bus.or_out  = bus.a | bus.b;
    assign bus.nor_out = ~(bus.a | bus.b);

    // Select the op result and derive its zero flag for capture.
    always_comb begin
        w_sel       = f_select(bus.op, bus.a, bus.b);
        w_zero_next = (w_sel == {WIDTH{1'b0}});
    end

    // Registered path: reset wins over a same-edge beat; idle cycles hold data.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_result    <= {WIDTH{1'b0}};
            r_zero      <= 1'b1;
            r_out_valid <= 1'b0;
        end else if (bus.in_valid) begin
            r_result    <= w_sel;
            r_zero      <= w_zero_next;
            r_out_valid <= 1'b1;
        end else begin
            r_out_valid <= 1'b0;
        end
    end

    assign bus.result    = r_result;
    assign bus.zero      = r_zero;
    assign bus.out_valid = r_out_valid;
endmodule

// File: tb/tb_alu_gates.sv
// Directed table-driven bench for alu_gates: combinational gate vectors,
// registered op/zero vectors, and reset/hold/back-to-back sequences.
module tb_alu_gates;
    logic clk;
    logic reset;
    int   total;
    int   bad;

    alu_gates_if #(.WIDTH(32)) bus ();

    alu_gates #(.WIDTH(32)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_and;
        logic [31:0] exp_or;
        logic [31:0] exp_nor;
    } comb_vec_t;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_result;
        logic        exp_zero;
    } reg_vec_t;

    comb_vec_t comb_tbl[3];
    reg_vec_t  reg_tbl[6];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        total = 0;
        bad   = 0;

        comb_tbl[0] = '{32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 32'hC000_0000, 32'h3FFF_FFFF};
        comb_tbl[1] = '{32'h0003_FFFF, 32'h007F_C000, 32'h0003_C000, 32'h007F_FFFF, 32'hFF80_0000};
        comb_tbl[2] = '{32'hAAAA_AAAA, 32'h3333_3333, 32'h2222_2222, 32'hBBBB_BBBB, 32'h4444_4444};

        reg_tbl[0] = '{2'b00, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b1};
        reg_tbl[1] = '{2'b01, 32'h8000_0000, 32'h4000_0000, 32'hC000_0000, 1'b0};
        reg_tbl[2] = '{2'b11, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b1};
        reg_tbl[3] = '{2'b10, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0000, 1'b1};
        reg_tbl[4] = '{2'b10, 32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0};
        reg_tbl[5] = '{2'b00, 32'hAAAA_AAAA, 32'h3333_3333, 32'h2222_2222, 1'b0};

        reset        = 1'b1;
        bus.a        = 32'h0;
        bus.b        = 32'h0;
        bus.op       = 2'b00;
        bus.in_valid = 1'b0;
        tick();
        chk("reset_result", bus.result, 32'h0);
        chk("reset_zero", {31'b0, bus.zero}, 32'h1);
        chk("reset_valid", {31'b0, bus.out_valid}, 32'h0);
        reset = 1'b0;
        tick();

        for (int i = 0; i < 3; i++) begin
            bus.a = comb_tbl[i].a;
            bus.b = comb_tbl[i].b;
            #1;
            chk($sformatf("comb%0d_and", i), bus.and_out, comb_tbl[i].exp_and);
            chk($sformatf("comb%0d_or", i),  bus.or_out,  comb_tbl[i].exp_or);
            chk($sformatf("comb%0d_nor", i), bus.nor_out, comb_tbl[i].exp_nor);
        end

        // registered vectors applied back to back
        for (int i = 0; i < 6; i++) begin
            bus.op       = reg_tbl[i].op;
            bus.a        = reg_tbl[i].a;
            bus.b        = reg_tbl[i].b;
            bus.in_valid = 1'b1;
            tick();
            chk($sformatf("reg%0d_result", i), bus.result, reg_tbl[i].exp_result);
            chk($sformatf("reg%0d_zero", i), {31'b0, bus.zero}, {31'b0, reg_tbl[i].exp_zero});
            chk($sformatf("reg%0d_valid", i), {31'b0, bus.out_valid}, 32'h1);
        end
        bus.in_valid = 1'b0;
        tick();
        chk("idle_hold_result", bus.result, 32'h2222_2222);
        chk("idle_hold_zero", {31'b0, bus.zero}, 32'h0);
        chk("idle_valid", {31'b0, bus.out_valid}, 32'h0);

        // reset on the same edge as a beat discards the beat
        reset        = 1'b1;
        bus.in_valid = 1'b1;
        bus.op       = 2'b01;
        bus.a        = 32'hFFFF_FFFF;
        bus.b        = 32'hFFFF_FFFF;
        tick();
        chk("rst_beat_result", bus.result, 32'h0);
        chk("rst_beat_zero", {31'b0, bus.zero}, 32'h1);
        chk("rst_beat_valid", {31'b0, bus.out_valid}, 32'h0);
        chk("rst_comb_or", bus.or_out, 32'hFFFF_FFFF);
        chk("rst_comb_nor", bus.nor_out, 32'h0);
        reset        = 1'b0;
        bus.in_valid = 1'b0;
        tick();
        chk("post_rst_result", bus.result, 32'h0);
        chk("post_rst_valid", {31'b0, bus.out_valid}, 32'h0);

        // back-to-back beats on the overlap operands
        bus.a        = 32'h0003_FFFF;
        bus.b        = 32'h007F_C000;
        bus.in_valid = 1'b1;
        bus.op       = 2'b00;
        tick();
        chk("b2b0_result", bus.result, 32'h0003_C000);
        chk("b2b0_valid", {31'b0, bus.out_valid}, 32'h1);
        bus.op = 2'b01;
        tick();
        chk("b2b1_result", bus.result, 32'h007F_FFFF);
        chk("b2b1_valid", {31'b0, bus.out_valid}, 32'h1);
        bus.op = 2'b10;
        tick();
        chk("b2b2_result", bus.result, 32'hFF80_0000);
        chk("b2b2_zero", {31'b0, bus.zero}, 32'h0);
        chk("b2b2_valid", {31'b0, bus.out_valid}, 32'h1);
        bus.in_valid = 1'b0;
        bus.op       = 2'b11;
        tick();
        chk("b2b_end_valid", {31'b0, bus.out_valid}, 32'h0);
        chk("b2b_end_hold", bus.result, 32'hFF80_0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/alu_gates.md
# alu_gates

Bitwise logic unit for the ALU datapath. It provides 32-bit AND, OR and NOR of two operands as zero-latency combinational outputs, one per gate. It also provides a clocked, op-selected result with a zero flag for the pipelined ALU stage. The combinational outputs serve the ALU's result multiplexer; the registered path feeds the writeback stage.

## Interface
- WIDTH, 32, operand and result width in bits (all ports below scale with it)
- clk  input  1  rising-edge clock for the registered path
- reset  input  1  synchronous, active-high reset
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- op  input  2  registered-path select: 00 AND, 01 OR, 10 NOR, 11 reserved
- in_valid  input  1  operands and op on this edge are to be captured
- and_out  output  WIDTH  a & b, combinational
- or_out  output  WIDTH  a | b, combinational
- nor_out  output  WIDTH  ~(a | b), combinational
- result  output  WIDTH  registered result of the selected op
- zero  output  1  registered; 1 when result is all zeros
- out_valid  output  1  registered; result and zero hold a new value

## Operation
- The design uses one clock (clk). Reset is synchronous and active-high.
- and_out, or_out and nor_out are pure per-bit functions of a and b.
  - They are independent of clk, reset, op and in_valid.
  - Each output bit i depends only on a[i] and b[i].
  - No carry or cross-bit interaction.
- Selected value sel:
  - op=00: a & b
  - op=01: a | b
  - op=10: ~(a | b)
  - op=11 (reserved): all zeros
- zero_next = (sel == 0).
  - It reflects sel even for op=11, so reserved op yields zero=1.
- Registered path, on each rising clk edge:
  - If reset=1: result<=0, zero<=1, out_valid<=0. This overrides in_valid.
  - Else if in_valid=1: result<=sel, zero<=zero_next, out_valid<=1.
  - Else: result and zero hold their previous values, out_valid<=0.
- No backpressure. Every in_valid beat is accepted, and back-to-back beats produce back-to-back results.
- No X-propagation requirement beyond standard simulation semantics. Outputs are fully defined whenever inputs are 0/1.

## Timing
- Combinational outputs:
  - Latency is 0 cycles; outputs settle within the same delta/propagation window as a and b.
  - They stay valid throughout reset.
- Registered path:
  - Latency is 1 cycle: inputs sampled at edge N appear on result, zero and out_valid after edge N.
  - out_valid is a single-cycle pulse per accepted beat.
- Reset:
  - Reset values are result=0, zero=1, out_valid=0, applied at the first clk edge with reset=1.
  - Before the first edge, registered outputs are undefined.
- Reset mid-operation: a beat presented on the same edge as reset=1 is discarded. The output after that edge is the reset value.
- Simultaneous op change and in_valid: the op value sampled at the capturing edge is the one used.

## Test plan
- Combinational OR/AND/NOR, first vector: a=0x80000000, b=0x40000000 -> or_out=0xC0000000, and_out=0x00000000, nor_out=0x3FFFFFFF.
- Combinational overlap vector: a=0x0003FFFF, b=0x007FC000 -> or_out=0x007FFFFF, and_out=0x0003C000, nor_out=0xFF800000.
- NOR alternating patterns: a=0xAAAAAAAA, b=0x33333333 -> nor_out=0x44444444, or_out=0xBBBBBBBB, and_out=0x22222222.
- Registered path and zero flag:
  - in_valid=1, op=00, a=0x80000000, b=0x40000000 -> next cycle result=0, zero=1, out_valid=1.
  - Then op=01 -> result=0xC0000000, zero=0.
  - Then op=11 -> result=0, zero=1.
- Reset and hold:
  - Assert reset with in_valid=1, op=01, a=b=0xFFFFFFFF -> after the edge result=0, zero=1, out_valid=0. Combinational outputs still show or_out=0xFFFFFFFF and nor_out=0.
  - Deassert reset with in_valid=0 -> result holds and out_valid=0.
- Back-to-back beats: three consecutive in_valid cycles with op=00, 01, 10 and a=0x0003FFFF, b=0x007FC000 -> results 0x0003C000, 0x007FFFFF, 0xFF800000 on consecutive cycles, with out_valid high for all three.
